i2c_slave: RTL

- I2C target (responder) that answers the team's I2C master on a shared SDA/SCL bus.
- Oversamples SCL/SDA on the system clock, detects START/STOP and matches a fixed 7-bit address.
- Write transfers: accepts bytes from the master and presents them on a byte-valid interface.
- Read transfers: serialises bytes supplied by local logic. No clock stretching; SCL is input only.

---
 rtl/i2c_slave.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave.sv
// I2C target: oversampled SCL/SDA, START/STOP detection, fixed 7-bit address match,
// byte-valid write path and tx_req-driven read path. SCL is never stretched.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    output logic       busy,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        RX_DATA   = 4'd3,
        RX_ACK    = 4'd4,
        TX_DATA   = 4'd5,
        TX_ACK    = 4'd6,
        WAIT_STOP = 4'd7
    } state_t;

    state_t      state_q, state_d;
    logic        scl_s1_q, scl_s2_q, scl_h_q;
    logic        sda_s1_q, sda_s2_q, sda_h_q;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [6:0]  tx_shift_q, tx_shift_d;
    logic        sda_oe_q, sda_oe_d;
    logic        rw_q, rw_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        tx_req_q, tx_req_d;
    logic        load_tx;

    logic scl_rise, scl_fall, start_det, stop_det;

    // Synchronisers idle high so reset never fabricates a bus condition.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            scl_h_q  <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            sda_h_q  <= 1'b1;
        end else begin
            scl_s1_q <= i2c_scl;
            scl_s2_q <= scl_s1_q;
            scl_h_q  <= scl_s2_q;
            sda_s1_q <= i2c_sda;
            sda_s2_q <= sda_s1_q;
            sda_h_q  <= sda_s2_q;
        end
    end

    assign scl_rise  = scl_s2_q & ~scl_h_q;
    assign scl_fall  = ~scl_s2_q & scl_h_q;
    assign start_det = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
    assign stop_det  = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_shift_q <= '0;
            sda_oe_q   <= 1'b0;
            rw_q       <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_shift_q <= tx_shift_d;
            sda_oe_q   <= sda_oe_d;
            rw_q       <= rw_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_shift_d = tx_shift_q;
        sda_oe_d   = sda_oe_q;
        rw_d       = rw_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        load_tx    = 1'b0;

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_s2_q};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = '0;
                        if (shift_q[7:1] == SLAVE_ADDR) begin
                            sda_oe_d = 1'b1;
                            rw_d     = shift_q[0];
                            state_d  = ADDR_ACK;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw_q) begin
                            load_tx = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = RX_DATA;
                        end
                    end
                end
                RX_DATA: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_s2_q};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            rx_data_d  = {shift_q[6:0], sda_s2_q};
                            rx_valid_d = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_oe_d = 1'b1;
                        state_d  = RX_ACK;
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = RX_DATA;
                    end
                end
                // bit_cnt counts bits already placed on the bus (bit7 at load).
                TX_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q < 4'd8) begin
                            sda_oe_d   = ~tx_shift_q[6];
                            tx_shift_d = {tx_shift_q[5:0], 1'b0};
                            bit_cnt_d  = bit_cnt_q + 4'd1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = TX_ACK;
                        end
                    end
                end
                // bit_cnt==9 marks "master ACKed, reload on next fall".
                TX_ACK: begin
                    if (scl_rise) begin
                        if (sda_s2_q) state_d   = WAIT_STOP;
                        else          bit_cnt_d = 4'd9;
                    end else if (scl_fall && bit_cnt_q == 4'd9) begin
                        load_tx = 1'b1;
                    end
                end
                IDLE, WAIT_STOP: sda_oe_d = 1'b0;
                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end

        if (load_tx) begin
            tx_shift_d = tx_data[6:0];
            sda_oe_d   = ~tx_data[7];
            tx_req_d   = 1'b1;
            bit_cnt_d  = 4'd1;
            state_d    = TX_DATA;
        end
    end

    always_comb begin
        busy     = (state_q == ADDR_ACK) || (state_q == RX_DATA) || (state_q == RX_ACK) ||
                   (state_q == TX_DATA)  || (state_q == TX_ACK);
        state    = state_q;
        rx_data  = rx_data_q;
        rx_valid = rx_valid_q;
        tx_req   = tx_req_q;
    end

    assign i2c_sda = sda_oe_q ? 1'b0 : 1'bz;

endmodule
